// File: rtl/fixed_mul_arbiter.sv
// fixed_mul_arbiter: round-robin front end for one shared, two-stage
// unsigned fixed-point multiplier. One operand pair is accepted per cycle.
// The result is rounded half-up back to INTW.RATW and returned with the
// requester ID two cycles after the grant.
module fixed_mul_arbiter #(
  parameter int INTW = 10,
  parameter int RATW = 10,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*(INTW+RATW)-1:0]   req_a,
  input  logic [NREQ*(INTW+RATW)-1:0]   req_b,
  output logic [NREQ-1:0]               req_ready,
  output logic                          resp_valid,
  output logic [IDW-1:0]                resp_id,
  output logic [INTW+RATW-1:0]          resp_data
);

  localparam int W = INTW + RATW;
  // Half an output ulp, expressed in product units, for round-half-up.
  localparam logic [2*W-1:0] HALF = {{(2*W-1){1'b0}}, 1'b1} << (RATW - 1);

  // Priority pointer and pipeline registers
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           v1_q, v1_d;
  logic [IDW-1:0] id1_q, id1_d;
  logic [W-1:0]   a1_q, a1_d;
  logic [W-1:0]   b1_q, b1_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [W-1:0]   resp_data_q, resp_data_d;

  // Arbitration results
  logic           found;
  logic           hs;
  logic [IDW-1:0] gnt_idx;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [2*W-1:0] prod;

  // Round-robin scan starting at ptr_q; grant the first valid requester.
  always_comb begin
    logic [IDW:0] idx;
    found     = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[IDW-1:0];
      end
    end
    // No grant may be issued while the block is held in reset.
    hs = found & ~rst;
    if (hs) begin
      req_ready[gnt_idx] = 1'b1;
    end
    a_sel = req_a[gnt_idx*W +: W];
    b_sel = req_b[gnt_idx*W +: W];
  end

  // Full-width unsigned product of the stage-1 operands.
  assign prod = {{W{1'b0}}, a1_q} * {{W{1'b0}}, b1_q};

  // Next-state: pointer advance, stage-1 capture, stage-2 round and output.
  always_comb begin
    ptr_d        = ptr_q;
    v1_d         = hs;
    id1_d        = id1_q;
    a1_d         = a1_q;
    b1_d         = b1_q;
    resp_valid_d = v1_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    if (hs) begin
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      id1_d = gnt_idx;
      a1_d  = a_sel;
      b1_d  = b_sel;
    end
    // Outputs hold their last value between results; overflow wraps.
    if (v1_q) begin
      resp_id_d   = id1_q;
      resp_data_d = W'((prod + HALF) >> RATW);
    end
  end

  // State registers with synchronous reset; reset drops in-flight results.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      v1_q         <= 1'b0;
      id1_q        <= '0;
      a1_q         <= '0;
      b1_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      v1_q         <= v1_d;
      id1_q        <= id1_d;
      a1_q         <= a1_d;
      b1_q         <= b1_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// Self-checking bench for fixed_mul_arbiter: directed cases plus a random
// phase, all checked every cycle against a behavioural model.
module tb_fixed_mul_arbiter;

  localparam int INTW = 10;
  localparam int RATW = 10;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = INTW + RATW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_a;
  logic [NREQ*W-1:0]    req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic [IDW-1:0]       resp_id;
  logic [W-1:0]         resp_data;

  int checks = 0;
  int errors = 0;

  fixed_mul_arbiter #(.INTW(INTW), .RATW(RATW), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fixed-point product rounded half-up, wrapped to W bits.
  function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    p = (p + (64'd1 << (RATW - 1))) >> RATW;
    return p[W-1:0];
  endfunction

  // Round-robin pick: first valid index scanning from ptr, or -1.
  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Model state: pointer, one accepted-but-not-returned slot, visible outputs.
  int              m_ptr = 0;
  bit              live  = 1'b0;
  bit              s1_v  = 1'b0;
  int              s1_id = 0;
  logic [W-1:0]    s1_d  = '0;
  bit              o_v   = 1'b0;
  int              o_id  = 0;
  logic [W-1:0]    o_d   = '0;
  int              cmp_g;
  logic [NREQ-1:0] exp_ready;

  // Compare DUT against the model mid-cycle, then advance the model past the edge.
  always @(negedge clk) begin
    cmp_g     = pick(m_ptr, req_valid);
    exp_ready = '0;
    if (!rst && cmp_g >= 0) exp_ready[cmp_g] = 1'b1;
    if (rst || live) check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (live) begin
      check("resp_valid", 64'(resp_valid), 64'(o_v));
      check("resp_id", 64'(resp_id), 64'(o_id));
      check("resp_data", 64'(resp_data), 64'(o_d));
    end
    if (rst) begin
      live  = 1'b1;
      m_ptr = 0;
      s1_v  = 1'b0;
      o_v   = 1'b0;
      o_id  = 0;
      o_d   = '0;
    end else if (live) begin
      o_v = s1_v;
      if (s1_v) begin
        o_id = s1_id;
        o_d  = s1_d;
      end
      s1_v = (cmp_g >= 0);
      if (cmp_g >= 0) begin
        s1_id = cmp_g;
        s1_d  = fx_mul(req_a[cmp_g*W +: W], req_b[cmp_g*W +: W]);
        m_ptr = (cmp_g + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single requester transaction with literal expectations at T and T+2.
  task automatic one_shot(input string name, input int lane, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
    logic [NREQ-1:0] onehot;
    onehot = '0;
    onehot[lane] = 1'b1;
    req_valid = onehot;
    req_a[lane*W +: W] = a;
    req_b[lane*W +: W] = b;
    @(negedge clk);
    check({name, "_ready"}, 64'(req_ready), 64'(onehot));
    step();
    req_valid = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    check({name, "_valid"}, 64'(resp_valid), 64'd1);
    check({name, "_id"}, 64'(resp_id), 64'(lane));
    check({name, "_data"}, 64'(resp_data), 64'(exp));
    $display("txn %s: lane=%0d a=0x%0h b=0x%0h data=0x%0h", name, lane, a, b, resp_data);
    step();
  endtask

  logic [NREQ-1:0] granted;

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;

    // Pin the model arithmetic with hand-computed values.
    check("pin_mul_1p5x2", 64'(fx_mul(20'h00600, 20'h00800)), 64'h00C00);
    check("pin_round_up", 64'(fx_mul(20'd1, 20'd512)), 64'd1);
    check("pin_round_dn", 64'(fx_mul(20'd1, 20'd511)), 64'd0);
    check("pin_wrap", 64'(fx_mul(20'h80000, 20'h80000)), 64'd0);

    // Reset held three edges with every requester asking.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd0);
      if (c > 0) check("rst_resp_valid", 64'(resp_valid), 64'd0);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'((i + 1) << RATW);
      req_b[i*W +: W] = 20'h00400;
    end

    // Fairness: all valid for 8 cycles starting at ptr 0.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 8) check("rr_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (c >= 2) begin
        check("rr_resp_valid", 64'(resp_valid), 64'd1);
        check("rr_resp_id", 64'(resp_id), 64'((c - 2) % 4));
      end else begin
        check("rr_resp_idle", 64'(resp_valid), 64'd0);
      end
      $display("txn rr cycle %0d: ready=%b resp_valid=%0d resp_id=%0d", c, req_ready, resp_valid, resp_id);
      step();
      req_valid = (c + 1 < 8) ? 4'hF : 4'h0;
    end

    one_shot("basic", 2, 20'h00600, 20'h00800, 20'h00C00);
    one_shot("round_half", 0, 20'd1, 20'd512, 20'd1);
    one_shot("round_below", 1, 20'd1, 20'd511, 20'd0);
    one_shot("wrap", 3, 20'h80000, 20'h80000, 20'd0);

    // Mid-flight reset drops the granted result.
    req_valid = 4'b0010;
    @(negedge clk);
    check("mf_ready", 64'(req_ready), 64'b0010);
    step();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mf_no_resp", 64'(resp_valid), 64'd0);
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    check("sparse_ready", 64'(req_ready), 64'b1000);
    step();
    req_valid = 4'hF;
    @(negedge clk);
    check("sparse_ptr_wrap", 64'(req_ready), 64'b0001);
    $display("txn sparse: req3 granted, next grant=%b", req_ready);
    step();
    req_valid = '0;

    // Random phase; requesters hold until granted or occasionally withdraw.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      granted = req_ready;
      if (resp_valid) $display("txn rnd %0d: id=%0d data=0x%0h", c, resp_id, resp_data);
      step();
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !granted[i] && $urandom_range(0, 9) != 0)) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          if ($urandom_range(0, 1) == 0) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
          end else begin
            req_a[i*W +: W] = W'($urandom_range(0, 2047));
            req_b[i*W +: W] = W'($urandom_range(0, 1023));
          end
        end
      end
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (4) begin
      @(negedge clk);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_mul_arbiter.md
Name: fixed_mul_arbiter

Overview:
- Shares one pipelined fixed-point multiplier among NREQ requesters.
- Round-robin arbitration, one accept per cycle.
- Each accepted operand pair is multiplied at full width, rounded half-up back to INTW.RATW, and returned with the requester ID after a fixed 2-cycle latency.
- Sits between the datapath lanes (HAT-Lba compute units) and the single shared multiplier resource.

Parameters:
- INTW, 10, integer bits of each operand and of the result.
- RATW, 10, fractional bits of each operand and of the result (RATW >= 1).
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of the requester ID; IDW = clog2(NREQ).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  bit i set: requester i presents an operand pair.
- req_a  input  NREQ*(INTW+RATW)  packed operand A; lane i at [i*(INTW+RATW) +: INTW+RATW]; unsigned fixed point.
- req_b  input  NREQ*(INTW+RATW)  packed operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant; bit i high means requester i's pair is accepted this cycle.
- resp_valid  output  1  result valid, one-cycle pulse per result.
- resp_id  output  IDW  index of the requester that owns the result.
- resp_data  output  INTW+RATW  rounded product.

Behaviour:
- Reset: rst high at a clock edge clears the following:
  - both pipeline valid bits;
  - req_ready, resp_valid, resp_id and resp_data, all to 0;
  - the priority pointer, to 0.
- Reset mid-operation discards in-flight results. No resp_valid is produced for them.
- Arbitration (combinational from registered pointer ptr):
  - The granted requester is the first i with req_valid[i] = 1, scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1 (mod NREQ).
  - req_ready is one-hot for that i, or all-zero if no request is valid.
  - req_ready is forced to 0 while rst is high.
  - A handshake occurs on cycle T when req_valid[i] & req_ready[i].
- Pointer update: on a handshake with requester g, ptr <= (g+1) mod NREQ. With no handshake, ptr holds.
- No backpressure: the pipeline accepts one pair every cycle, so the grant depends only on req_valid and ptr.
- Requester contract:
  - A requester holds req_valid and its operands until it is granted.
  - Deasserting req_valid before grant is permitted and simply withdraws the request.
- Stage 1 (edge ending cycle T), registers:
  - a and b of the granted lane;
  - the ID g;
  - v1 = handshake.
- Stage 2 (edge ending cycle T+1):
  - p = a*b, full 2*(INTW+RATW) bits, unsigned.
  - r = (p + 2^(RATW-1)) >> RATW, i.e. round half up.
  - resp_data <= r[INTW+RATW-1:0]. Integer overflow wraps by truncating the high bits; there is no saturation.
  - resp_id <= stage-1 ID; resp_valid <= v1.
- Latency: a handshake in cycle T gives resp_valid = 1 in cycle T+2.
- Throughput is 1 result per cycle. Results return in grant order.
- When resp_valid = 0, resp_data and resp_id hold their previous values.
- Simultaneous events: all requesters valid every cycle gives grants in order ptr, ptr+1, ... with no starvation. Each requester waits at most NREQ-1 cycles.
- A single persistent requester with no competitors is granted every cycle.

Test Plan:
- Reset:
  - Stimulus: hold rst for 3 cycles with all req_valid = 1.
  - Required: req_ready = 0, resp_valid = 0 throughout.
  - Required: first grant after release goes to requester 0.
- Basic multiply (INTW = RATW = 10):
  - Stimulus: req 2 presents a = 0x600 (1.5), b = 0x800 (2.0) in cycle T.
  - Required: req_ready = 4'b0100 in T.
  - Required: in T+2, resp_valid = 1, resp_id = 2, resp_data = 0xC00 (3.0).
- Rounding boundary:
  - Stimulus: a = 1, b = 512 (product exactly 0.5 ulp).
  - Required: resp_data = 1.
  - Stimulus: a = 1, b = 511.
  - Required: resp_data = 0.
- Overflow wrap:
  - Stimulus: a = b = 0x80000 (512.0).
  - Required: resp_data = 0.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously for 8 cycles starting from ptr = 0.
  - Required: grants 0, 1, 2, 3, 0, 1, 2, 3.
  - Required: resp_id follows the same order, delayed 2 cycles.
- Mid-flight reset and sparse requests:
  - Stimulus: grant req 1 in T, assert rst in T+1.
  - Required: no resp_valid in T+2.
  - Stimulus: after reset, only req 3 valid.
  - Required: granted immediately, ptr becomes 0.
